sg_apb_uart_tx_fifo: RTL
========================

# sg_apb_uart_tx_fifo

This block is a parametrised APB UART transmitter with a TX FIFO, runtime-programmable baud divisor, optional parity and 1 or 2 stop bits. It is the successor to the single-register `sg_uart_tx`. It sits on the same APB bus as the other SoC peripherals (PADDR[11:2] word addressing) and drives one serial TXD pin.

## Interface
- FIFO_DEPTH, 16: TX FIFO entries; power of 2, 2..256.
- DATA_BITS, 8: data bits per frame, 5..9.
- BAUDDIV_RST, 434: reset value of BAUDDIV (50 MHz / 115200).
- CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB device select.
- PADDR  in  [11:2]  APB word address.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write control.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data; 0 when not (PSEL & !PWRITE).
- PREADY  out  1  tied 1; no wait states.
- TXD  out  1  serial output, idle high.
- TXEN  out  1  high while a frame is on the line.
- TXINT  out  1  level interrupt: CTRL.EN & FIFO empty & !TXEN.

## Operation
- APB write commits on the rising edge with PSEL & PENABLE & PWRITE. Reads are combinational from register state.
- Register map (byte offset):
  - 0x00 DATA (W): pushes PWDATA[DATA_BITS-1:0]. When the FIFO is full, the data is dropped and OVF is set. Reads return 0.
  - 0x04 STATUS (R/W1C): [0] TXEN, [1] full, [2] empty, [3] OVF sticky (write 1 clears), [8 +: clog2(FIFO_DEPTH)+1] fill level.
  - 0x08 CTRL (RW, reset 0): [0] EN, [1] PAREN, [2] PARODD, [3] STOP2.
  - 0x0C BAUDDIV (RW, [15:0], reset BAUDDIV_RST): bit period in CLK cycles. Values below 16 behave as 16; reads return the written value.
  - Other offsets: reads return 0, writes are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TXD=1. If EN and the FIFO is not empty: pop, load the shifter, and latch BAUDDIV, PAREN, PARODD and STOP2 for the whole frame. Then go to START.
  - START: TXD=0 for one bit period, then DATA.
  - DATA: DATA_BITS periods, LSB first. Then PARITY if PAREN, else STOP.
  - PARITY: one period. TXD = XOR(data) ^ PARODD, so even parity is the default.
  - STOP: TXD=1 for 1 period, or 2 periods if STOP2. Then IDLE.
- Clearing EN mid-frame: the current frame completes, and no further pops occur.
- A write to BAUDDIV or CTRL mid-frame takes effect from the next frame.
- Simultaneous push and pop on a full FIFO: the push is accepted and the level stays the same.
- A push on a full FIFO without a pop is dropped and sets OVF.
- An OVF set and a W1C in the same cycle: the set wins.
- The FIFO read/write pointers wrap modulo FIFO_DEPTH. Full and empty are derived from the level counter.

## Timing
- Reset values: TXD=1, TXEN=0, TXINT=0, PRDATA=0, PREADY=1. The FIFO is emptied, OVF=0, CTRL=0, BAUDDIV=BAUDDIV_RST, and the FSM goes to IDLE.
- RESET asserted mid-frame aborts the frame: TXD=1 from the next edge.
- Write latency: a DATA write committed at edge E0 makes the level visible after E0.
  - If EN and IDLE: the pop occurs at E1, and TXD=0 and TXEN=1 from E1.
  - The start bit covers E1..E1+B-1, where B is the effective divisor.
- Frame length in cycles = B × (1 + DATA_BITS + PAREN + 1 + STOP2). TXEN is high for exactly that many cycles.
- Back-to-back frames: after the last stop period there is exactly 1 IDLE cycle (TXD=1, TXEN=0) before the next start bit.
- TXINT is registered. It rises on the edge after the conditions become true.

## Test plan
- Basic frame: BAUDDIV=16, EN=1, write DATA=0x55 → TXD 0,1,0,1,0,1,0,1,0,1 with each bit 16 cycles, TXEN high for 160 cycles, then TXINT=1.
- Parity: BAUDDIV=16, PAREN=1, write 0x07 → parity bit 1. With PARODD=1, the same data gives parity bit 0. Frame length is 176 cycles; with STOP2=1 it is 192 cycles.
- FIFO fill and overflow: EN=0, write 17 bytes 0x00..0x10 → STATUS shows full=1, level=16, OVF=1. Set EN=1 → 16 frames carry 0x00..0x0F in order, each separated by 1 idle cycle. Write 0x08 to STATUS → OVF=0.
- Divisor clamp and frame latching: BAUDDIV=5 → bit period is 16 cycles. Write BAUDDIV=32 mid-frame → the current frame stays at 16-cycle bits and the next frame uses 32.
- Simultaneous events: fill the FIFO while IDLE and push in the pop cycle → level stays 16 and OVF stays 0. Clear EN mid-frame → the frame completes and TXD stays 1 afterwards.
- Reset mid-frame: assert RESET during DATA → TXD=1, TXEN=0, STATUS empty=1 and level=0, and BAUDDIV reads back 434.

Source files
------------

// File: rtl/sg_apb_uart_tx_fifo.sv
// sg_apb_uart_tx_fifo: APB UART transmitter with a TX FIFO, programmable
// baud divisor, optional parity and one or two stop bits.
//
// Ports:
//   CLK, RESET        single clock, synchronous active-high reset
//   PSEL, PADDR[11:2] APB select and word address
//   PENABLE, PWRITE   APB access phase and direction
//   PWDATA, PRDATA    APB write / read data (PRDATA is 0 unless PSEL & !PWRITE)
//   PREADY            always 1, no wait states
//   TXD               serial output, idle high
//   TXEN              high while a frame is on the line
//   TXINT             registered level interrupt: EN & FIFO empty & !TXEN
//
// Register map (byte offset): 0x00 DATA (W), 0x04 STATUS (R/W1C),
// 0x08 CTRL (RW), 0x0C BAUDDIV (RW).
module sg_apb_uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned BAUDDIV_RST = 434
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PSEL,
    input  logic [11:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        TXD,
    output logic        TXEN,
    output logic        TXINT
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [15:0]   BAUD_MIN  = 16'd16;

    localparam logic [9:0] ADDR_DATA   = 10'h000;
    localparam logic [9:0] ADDR_STATUS = 10'h001;
    localparam logic [9:0] ADDR_CTRL   = 10'h002;
    localparam logic [9:0] ADDR_BAUD   = 10'h003;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Register file
    logic                 r_en, r_paren, r_parodd, r_stop2;
    logic [15:0]          r_baud;
    logic                 r_ovf;
    logic                 r_txint;

    // FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [LW-1:0]        r_level;

    // Transmitter
    state_t               r_state, w_state_nxt;
    logic [15:0]          r_div;
    logic [15:0]          r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_f_paren, r_f_stop2;

    logic                 w_wr, w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_baud;
    logic                 w_empty, w_full, w_pop, w_push_ok, w_push_fail;
    logic                 w_bit_end, w_txd, w_txen;
    logic [15:0]          w_baud_eff;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_wr_data = w_wr && (PADDR == ADDR_DATA);
    assign w_wr_stat = w_wr && (PADDR == ADDR_STATUS);
    assign w_wr_ctrl = w_wr && (PADDR == ADDR_CTRL);
    assign w_wr_baud = w_wr && (PADDR == ADDR_BAUD);

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == DEPTH_L);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_push_ok   = w_wr_data && (!w_full || w_pop);
    assign w_push_fail = w_wr_data && w_full && !w_pop;

    assign w_baud_eff = (r_baud < BAUD_MIN) ? BAUD_MIN : r_baud;
    assign w_bit_end  = (r_baud_cnt == r_div - 16'd1);
    assign w_txen     = (r_state != S_IDLE);

    assign w_unused = &{1'b0, PWDATA[31:16]};

    // Register file, FIFO pointers, sticky overflow and interrupt
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_en     <= 1'b0;
            r_paren  <= 1'b0;
            r_parodd <= 1'b0;
            r_stop2  <= 1'b0;
            r_baud   <= 16'(BAUDDIV_RST);
            r_ovf    <= 1'b0;
            r_txint  <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= PWDATA[0];
                r_paren  <= PWDATA[1];
                r_parodd <= PWDATA[2];
                r_stop2  <= PWDATA[3];
            end
            if (w_wr_baud) begin
                r_baud <= PWDATA[15:0];
            end
            // Overflow set takes priority over a write-1-to-clear.
            if (w_push_fail) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && PWDATA[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push_ok) begin
                r_level <= r_level - LW'(1);
            end
            r_txint <= r_en && w_empty && !w_txen;
        end
    end

    // FIFO storage needs no reset: the level counter guards every read.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= PWDATA[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end && (r_bit_cnt == LAST_DATA)) begin
                    w_state_nxt = r_f_paren ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_txd = r_par;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_bit_cnt == {3'b000, r_f_stop2})) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit timing and per-frame settings latched at the pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_div      <= BAUD_MIN;
            r_f_paren  <= 1'b0;
            r_f_stop2  <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
            // Bit index restarts on every state change; STOP uses it to count stop bits.
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_pop) begin
                r_shift   <= r_mem[r_rptr];
                r_par     <= (^r_mem[r_rptr]) ^ r_parodd;
                r_div     <= w_baud_eff;
                r_f_paren <= r_paren;
                r_f_stop2 <= r_stop2;
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_STATUS: begin
                    w_rdata[0]       = w_txen;
                    w_rdata[1]       = w_full;
                    w_rdata[2]       = w_empty;
                    w_rdata[3]       = r_ovf;
                    w_rdata[8 +: LW] = r_level;
                end
                ADDR_CTRL: begin
                    w_rdata[3:0] = {r_stop2, r_parodd, r_paren, r_en};
                end
                ADDR_BAUD: begin
                    w_rdata[15:0] = r_baud;
                end
                default: begin
                    w_rdata = '0;
                end
            endcase
        end
    end

    assign PRDATA = w_rdata;
    assign PREADY = 1'b1;
    assign TXD    = w_txd;
    assign TXEN   = w_txen;
    assign TXINT  = r_txint;

endmodule
